// File: rtl/mtrx_slice_fifo.sv
// mtrx_slice_fifo: synchronous width-converting FIFO.
//   Words of WR_WIDTH bits go in and RD_WIDTH-bit slices come out, most significant
//   slice first. Reads use standard mode: an accepted read loads dout at that edge.
//   Ports:
//     clk   - single clock, all logic on the rising edge
//     srst  - synchronous active-high reset
//     din   - write data word
//     wr_en - write request, ignored while full
//     rd_en - read request, ignored while empty
//     dout  - registered read slice, holds between accepted reads
//     full  - fewer than one word's worth of free slices
//     empty - no unread slice
module mtrx_slice_fifo #(
    parameter int unsigned WR_WIDTH = 64,
    parameter int unsigned RD_WIDTH = 8,
    parameter int unsigned WR_DEPTH = 16
) (
    input  logic                clk,
    input  logic                srst,
    input  logic [WR_WIDTH-1:0] din,
    input  logic                wr_en,
    input  logic                rd_en,
    output logic [RD_WIDTH-1:0] dout,
    output logic                full,
    output logic                empty
);

    localparam int unsigned SLICES = WR_WIDTH / RD_WIDTH;
    localparam int unsigned CAP    = WR_DEPTH * SLICES;
    localparam int unsigned AW     = (WR_DEPTH > 1) ? $clog2(WR_DEPTH) : 1;
    localparam int unsigned SW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int unsigned CW     = $clog2(CAP + 1);

    localparam logic [CW-1:0] FULL_THRESH = CW'(CAP - SLICES);
    localparam logic [CW-1:0] SLICE_INC   = CW'(SLICES);
    localparam logic [SW-1:0] LAST_SLICE  = SW'(SLICES - 1);

    // Storage needs no reset; validity is tracked by the slice count.
    logic [WR_WIDTH-1:0] mem [WR_DEPTH];

    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [SW-1:0]       slice_q, slice_d;
    logic [CW-1:0]       count_q, count_d;
    logic [RD_WIDTH-1:0] dout_q, dout_d;

    logic                wr_acc;
    logic                rd_acc;
    logic [WR_WIDTH-1:0] rd_word;
    logic [RD_WIDTH-1:0] rd_slice;

    assign full  = (count_q > FULL_THRESH);
    assign empty = (count_q == '0);
    assign dout  = dout_q;

    assign wr_acc = wr_en & ~full & ~srst;
    assign rd_acc = rd_en & ~empty & ~srst;

    assign rd_word = mem[rd_ptr_q];

    // Slice 0 is the most significant one, so slice index i maps to the
    // (SLICES-1-i)th RD_WIDTH lane of the word.
    always_comb begin
        rd_slice = '0;
        for (int i = 0; i < int'(SLICES); i++) begin
            if (slice_q == SW'(int'(SLICES) - 1 - i)) begin
                rd_slice = rd_word[i*RD_WIDTH +: RD_WIDTH];
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        slice_d  = slice_q;
        count_d  = count_q;
        dout_d   = dout_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_d + SLICE_INC;
        end

        if (rd_acc) begin
            dout_d  = rd_slice;
            count_d = count_d - CW'(1);
            // The word slot is released once its last slice has been read.
            if (slice_q == LAST_SLICE) begin
                slice_d  = '0;
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                slice_d = slice_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            slice_q  <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            slice_q  <= slice_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: tb/tb_mtrx_slice_fifo.sv
// Bench for mtrx_slice_fifo: a byte-queue reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_mtrx_slice_fifo;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic [63:0] din = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  dout;
    logic        full;
    logic        empty;

    int vectors = 0;
    int fails   = 0;
    bit chk_en  = 1'b0;

    // Reference model: unread bytes in order, plus the last byte read.
    logic [7:0] mq [$];
    logic [7:0] m_dout = '0;

    logic [7:0] exp_b [8];
    logic [7:0] got_b;

    mtrx_slice_fifo #(
        .WR_WIDTH(64),
        .RD_WIDTH(8),
        .WR_DEPTH(16)
    ) dut (
        .clk  (clk),
        .srst (srst),
        .din  (din),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .dout (dout),
        .full (full),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit do_rd;
        bit do_wr;
        if (srst) begin
            mq.delete();
            m_dout = '0;
        end else begin
            do_rd = rd_en && (mq.size() != 0);
            do_wr = wr_en && (mq.size() <= 120);
            if (do_rd) m_dout = mq.pop_front();
            if (do_wr) begin
                for (int i = 7; i >= 0; i--) mq.push_back(din[i*8 +: 8]);
            end
        end
    endtask

    // Drive inputs, let one rising edge happen, update the model, settle.
    task automatic step(input logic w, input logic r, input logic [63:0] d, input logic s);
        wr_en = w;
        rd_en = r;
        din   = d;
        srst  = s;
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dout", {56'd0, dout}, {56'd0, m_dout});
            chk("full", {63'd0, full}, {63'd0, (mq.size() > 120)});
            chk("empty", {63'd0, empty}, {63'd0, (mq.size() == 0)});
        end
    end

    initial begin
        exp_b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};

        // Reset state
        step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk_en = 1'b1;
        chk("rst_dout", {56'd0, dout}, 64'd0);
        chk("rst_empty", {63'd0, empty}, 64'd1);
        chk("rst_full", {63'd0, full}, 64'd0);

        // Basic and sustained read
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 64'h0000_0000_1234_5678, 1'b0);
        for (int k = 0; k < 24; k++) begin
            step(1'b0, 1'b1, '0, 1'b0);
            got_b = dout;
            chk("basic_rd", {56'd0, got_b}, {56'd0, exp_b[k % 8]});
            chk("basic_empty", {63'd0, empty}, 64'd0);
        end
        chk("words_left", 64'(mq.size()), 64'd56);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("dout_hold", {56'd0, dout}, 64'h78);

        // Fill to full; the 17th write must be dropped
        step(1'b0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            chk("fill_notfull", {63'd0, full}, 64'd0);
            step(1'b1, 1'b0, {8{8'(k + 8'h10)}} ^ 64'h0001_0203_0405_0607, 1'b0);
        end
        chk("fill_full", {63'd0, full}, 64'd1);
        step(1'b1, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
        chk("fill_17th", 64'(mq.size()), 64'd128);

        // Full release
        step(1'b0, 1'b1, '0, 1'b0);
        chk("rel_first", {56'd0, dout}, 64'h10);
        chk("rel_full1", {63'd0, full}, 64'd1);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1, '0, 1'b0);
        chk("rel_last", {56'd0, dout}, 64'h17);
        chk("rel_full8", {63'd0, full}, 64'd0);
        // Force pointer wrap with extra writes, then drain
        step(1'b1, 1'b0, 64'hA0A1_A2A3_A4A5_A6A7, 1'b0);
        for (int k = 0; k < 40; k++) step(1'b0, 1'b1, '0, 1'b0);
        step(1'b1, 1'b1, 64'hB0B1_B2B3_B4B5_B6B7, 1'b0);
        for (int k = 0; k < 200; k++) step(1'b0, 1'b1, '0, 1'b0);
        chk("wrap_drain_last", {56'd0, dout}, 64'hB7);
        chk("wrap_empty", {63'd0, empty}, 64'd1);

        // Empty underflow
        step(1'b0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, '0, 1'b0);
        chk("uf_dout", {56'd0, dout}, 64'd0);
        chk("uf_empty", {63'd0, empty}, 64'd1);
        step(1'b1, 1'b0, 64'h0102_0304_0506_0708, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk("uf_notempty", {63'd0, empty}, 64'd0);
            step(1'b0, 1'b1, '0, 1'b0);
        end
        chk("uf_last", {56'd0, dout}, 64'h08);
        chk("uf_empty8", {63'd0, empty}, 64'd1);

        // Simultaneous read/write, then reset mid-stream
        step(1'b1, 1'b0, 64'h1111_2222_3333_4444, 1'b0);
        step(1'b1, 1'b1, 64'h5555_6666_7777_8888, 1'b0);
        chk("sim_dout", {56'd0, dout}, 64'h11);
        chk("sim_count", 64'(mq.size()), 64'd15);
        step(1'b1, 1'b1, 64'h9999_AAAA_BBBB_CCCC, 1'b1);
        chk("mid_rst_empty", {63'd0, empty}, 64'd1);
        chk("mid_rst_full", {63'd0, full}, 64'd0);
        chk("mid_rst_dout", {56'd0, dout}, 64'd0);
        step(1'b1, 1'b0, 64'hC3C4_C5C6_C7C8_C9CA, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        chk("post_rst_rd", {56'd0, dout}, 64'hC3);

        // Randomized traffic in phases of varying read/write pressure
        for (int p = 0; p < 16; p++) begin
            int unsigned wp;
            int unsigned rp;
            wp = $urandom_range(10, 90);
            rp = $urandom_range(10, 90);
            for (int k = 0; k < 250; k++) begin
                step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                     {$urandom, $urandom}, $urandom_range(0, 299) == 0);
            end
        end

        step(1'b0, 1'b0, '0, 1'b0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
